// File: rtl/key_pkg.sv
// key_pkg: types and constants shared by the key conditioning blocks.
//   key_state_t            - debounce FSM state (2-bit)
//   KEY_STABLE_50MHZ_20MS  - stability window for 20 ms at CLOCK_50
package key_pkg;

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    WAIT_PRESS   = 2'd1,
    PRESSED      = 2'd2,
    WAIT_RELEASE = 2'd3
  } key_state_t;

  localparam int KEY_STABLE_50MHZ_20MS = 1_000_000;

endpackage

// File: rtl/key_sync.sv
// key_sync: 2-flop synchroniser for one asynchronous level (KEY or SW).
//   RST_VAL  - value both flops take during reset (the input's idle level)
//   clk, rst - clock, async active-high reset
//   d        - raw asynchronous input
//   q        - synchronised level, 2 cycles behind d
module key_sync #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [1:0] stg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) stg <= {2{RST_VAL}};
    else     stg <= {stg[0], d};
  end

  assign q = stg[1];

endmodule

// File: rtl/key_debounce_pulse.sv
// key_debounce_pulse: synchronise, debounce and edge-detect one pushbutton.
//   STABLE_CYCLES - synchronised cycles a new level must persist (>= 2)
//   ACTIVE_LOW    - 1: raw input low when pressed, 0: high when pressed
//   clk, rst      - board clock, async active-high reset
//   key_in        - raw bouncing input
//   key_level     - debounced level, 1 = pressed
//   key_press     - 1-cycle pulse on accepted press
//   key_release   - 1-cycle pulse on accepted release
module key_debounce_pulse
  import key_pkg::*;
#(
  parameter int STABLE_CYCLES = KEY_STABLE_50MHZ_20MS,
  parameter bit ACTIVE_LOW    = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic key_in,
  output logic key_level,
  output logic key_press,
  output logic key_release
);

  localparam int              CNT_W    = $clog2(STABLE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

  logic             key_s;
  logic             p;
  key_state_t       state, state_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic             press_nx, release_nx;

  // Resetting to the released raw level means a button held through reset
  // is seen as a fresh press once reset lifts.
  key_sync #(.RST_VAL(ACTIVE_LOW)) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (key_in),
    .q   (key_s)
  );

  assign p = key_s ^ ACTIVE_LOW;

  always_comb begin
    state_nx   = state;
    cnt_nx     = cnt;
    press_nx   = 1'b0;
    release_nx = 1'b0;
    unique case (state)
      IDLE: if (p) begin
        state_nx = WAIT_PRESS;
        cnt_nx   = '0;
      end
      WAIT_PRESS: begin
        if (!p) begin
          state_nx = IDLE;
          cnt_nx   = '0;
        end else if (cnt == CNT_LAST) begin
          state_nx = PRESSED;
          cnt_nx   = '0;
          press_nx = 1'b1;
        end else begin
          cnt_nx = cnt + 1'b1;
        end
      end
      PRESSED: if (!p) begin
        state_nx = WAIT_RELEASE;
        cnt_nx   = '0;
      end
      WAIT_RELEASE: begin
        if (p) begin
          state_nx = PRESSED;
          cnt_nx   = '0;
        end else if (cnt == CNT_LAST) begin
          state_nx   = IDLE;
          cnt_nx     = '0;
          release_nx = 1'b1;
        end else begin
          cnt_nx = cnt + 1'b1;
        end
      end
      default: begin
        state_nx = IDLE;
        cnt_nx   = '0;
      end
    endcase
  end

  // Level and pulses are registered off the next state so they change on the
  // same edge as the accepting transition.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      key_level   <= 1'b0;
      key_press   <= 1'b0;
      key_release <= 1'b0;
    end else begin
      state       <= state_nx;
      cnt         <= cnt_nx;
      key_level   <= (state_nx == PRESSED) || (state_nx == WAIT_RELEASE);
      key_press   <= press_nx;
      key_release <= release_nx;
    end
  end

endmodule

// File: tb/tb_key_debounce_pulse.sv
// Bench for key_debounce_pulse: two instances (ACTIVE_LOW 1 and 0) share
// clock and reset. A run-length reference model pushes the expected outputs
// each edge; a monitor pops and compares on the falling edge.
module tb_key_debounce_pulse;
  import key_pkg::*;

  localparam int         S  = 4;
  localparam logic [1:0] AL = 2'b01;   // index 0: active low, index 1: active high

  typedef struct packed {
    logic [1:0] lvl;
    logic [1:0] prs;
    logic [1:0] rls;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] key;
  logic [1:0] lvl, prs, rls;

  int n_chk  = 0;
  int n_fail = 0;

  exp_t sb[$];

  always #5 clk = ~clk;

  key_debounce_pulse #(.STABLE_CYCLES(S), .ACTIVE_LOW(1'b1)) dut0 (
    .clk(clk), .rst(rst), .key_in(key[0]),
    .key_level(lvl[0]), .key_press(prs[0]), .key_release(rls[0]));

  key_debounce_pulse #(.STABLE_CYCLES(S), .ACTIVE_LOW(1'b0)) dut1 (
    .clk(clk), .rst(rst), .key_in(key[1]),
    .key_level(lvl[1]), .key_press(prs[1]), .key_release(rls[1]));

  // Reference: raw input seen 2 edges late; the debounced level flips once the
  // delayed pressed-value has disagreed with it on S+1 consecutive edges.
  logic [1:0] h1, h2, mlvl;
  int         run [2];

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      h1 = AL; h2 = AL; mlvl = '0;
      run[0] = 0; run[1] = 0;
    end else begin
      exp_t e;
      e = '0;
      for (int d = 0; d < 2; d++) begin
        logic pv;
        pv    = h2[d] ^ AL[d];
        h2[d] = h1[d];
        h1[d] = key[d];
        if (pv != mlvl[d]) run[d]++;
        else               run[d] = 0;
        if (run[d] == S + 1) begin
          mlvl[d] = pv;
          run[d]  = 0;
          if (pv) e.prs[d] = 1'b1;
          else    e.rls[d] = 1'b1;
        end
        e.lvl[d] = mlvl[d];
      end
      sb.push_back(e);
    end
  end

  // Monitor: with reset active, or no edge since reset, outputs must be 0.
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      sb.delete();
      e = '0;
    end else if (sb.size() == 0) begin
      e = '0;
    end else begin
      e = sb.pop_front();
    end
    for (int d = 0; d < 2; d++) begin
      n_chk++;
      if ({lvl[d], prs[d], rls[d]} !== {e.lvl[d], e.prs[d], e.rls[d]}) begin
        n_fail++;
        $display("FAIL sb_dut%0d t=%0t lvl/prs/rls got %b%b%b want %b%b%b", d, $time,
                 lvl[d], prs[d], rls[d], e.lvl[d], e.prs[d], e.rls[d]);
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic check(input string nm, input int got, input int want);
    n_chk++;
    if (got != want) begin
      n_fail++;
      $display("FAIL %s got %0d want %0d", nm, got, want);
    end
  endtask

  // Count edges until the selected pulse of instance d appears (bounded).
  task automatic wait_pulse(input int d, input bit rel, input int want, input string nm);
    int n = 0;
    bit seen = 0;
    while (!seen && n < 30) begin
      @(posedge clk); #1; n++;
      seen = rel ? rls[d] : prs[d];
    end
    check(nm, seen ? n : -1, want);
    check({nm, "_lvl"}, int'(lvl[d]), rel ? 0 : 1);
  endtask

  task automatic pulse_rst_check(input string nm);
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    check(nm, int'({lvl, prs, rls}), 0);
    step(2);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    key = AL;             // both released
    step(3);
    rst = 1'b0;
    step(20);             // idle after reset: scoreboard expects zeros

    // clean press / release on the active-low instance
    key[0] = 1'b0;
    wait_pulse(0, 0, 7, "clean_press");
    step(13);
    key[0] = 1'b1;
    wait_pulse(0, 1, 7, "clean_release");
    step(5);

    // bounce: low 3, high 1, five times, then low
    repeat (5) begin
      key[0] = 1'b0; step(3);
      key[0] = 1'b1; step(1);
    end
    key[0] = 1'b0;
    wait_pulse(0, 0, 7, "bounce_press");
    step(5);

    // release abort: 2-cycle high blip while pressed
    key[0] = 1'b1; step(2);
    key[0] = 1'b0; step(15);
    check("abort_lvl", int'(lvl[0]), 1);

    // async reset while pressed; held button is re-reported afterwards
    pulse_rst_check("rst_async_pressed");
    wait_pulse(0, 0, 7, "held_through_rst");
    key[0] = 1'b1;
    wait_pulse(0, 1, 7, "release2");
    step(5);

    // reset in WAIT_PRESS with cnt = 2
    key[0] = 1'b0;
    step(5);
    check("pre_rst_state", int'(dut0.state), int'(WAIT_PRESS));
    check("pre_rst_cnt", int'(dut0.cnt), 2);
    #1 rst = 1'b1;
    #1;
    check("rst_state", int'(dut0.state), int'(IDLE));
    check("rst_cnt", int'(dut0.cnt), 0);
    check("rst_outs", int'({lvl, prs, rls}), 0);
    step(2);
    rst = 1'b0;
    wait_pulse(0, 0, 7, "press_after_rst");
    key[0] = 1'b1;
    wait_pulse(0, 1, 7, "release3");

    // active-high instance
    key[1] = 1'b1;
    wait_pulse(1, 0, 7, "al0_press");

    // random toggling on both inputs
    for (int i = 0; i < 800; i++) begin
      step(1);
      if ($urandom_range(0, 6) == 0) key[0] = ~key[0];
      if ($urandom_range(0, 6) == 0) key[1] = ~key[1];
    end
    pulse_rst_check("rst_async_rand");
    step(20);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
